dram_xfer_initiator: RTL and testbench
======================================

// Module: dram_xfer_initiator
// PURPOSE
//  Core-side initiator for the DRAM block-transfer interface (D_REQ/D_INITADR/D_BLOCKS/D_BUSY/D_W/D_DIN/D_DOUT/D_DOUTEN).
//  Accepts one read or write command at a time and issues a single one-cycle request.
//  Write: supplies one DW-bit block per D_W strobe from a write-source FIFO. Read: forwards each D_DOUTEN beat to a read-sink FIFO.
//  Placed between the sort core's phase controller and the DRAM controller; replaces ad-hoc request logic inside CORE.
// PARAMETERS
//  DW        512          block width; equals `DRAMW
//  CNTW      32           width of block counts and FIFO occupancy inputs
//  ADR_STEP  8            address increment per block
// PORTS
//  CLK           in   1     clock
//  RST_X         in   1     async reset, active-low
//  CMD_VALID     in   1     command present
//  CMD_WRITE     in   1     1 = write to DRAM, 0 = read from DRAM
//  CMD_ADR       in   32    initial address; must be a multiple of ADR_STEP
//  CMD_BLOCKS    in   CNTW  block count
//  CMD_READY     out  1     high in IDLE; command accepted when CMD_VALID && CMD_READY
//  XFER_DONE     out  1     one-cycle pulse on transfer completion
//  ERR           out  1     sticky protocol error flag
//  WD_DATA       in   DW    head of the write-source FIFO
//  WD_CNT        in   CNTW  write-source FIFO occupancy
//  WD_DEQ        out  1     pop the write-source FIFO
//  RD_DATA       out  DW    read block to the sink
//  RD_VALID      out  1     RD_DATA valid
//  RD_FREE       in   CNTW  free entries in the read sink
//  D_REQ         out  2     `DRAM_REQ_READ / `DRAM_REQ_WRITE / 0
//  D_INITADR     out  32    request address
//  D_BLOCKS      out  32    request block count
//  D_BUSY        in   1     DRAM controller busy
//  D_W           in   1     controller consumes one write block this cycle
//  D_DIN         out  DW    write data to the controller
//  D_DOUT        in   DW    read data from the controller
//  D_DOUTEN      in   1     D_DOUT valid
// BEHAVIOUR
//  Reset: all outputs 0 except CMD_READY=1. State IDLE, counters 0, ERR=0.
//  Reset mid-transfer abandons the transfer. No DRAM-side cleanup is performed.
//  FSM states: IDLE, GATE, ISSUE, WAITB, XFER, DONE.
//  - IDLE: on accept, latch direction, address and count.
//    - CMD_BLOCKS==0: no request is issued; go to DONE.
//    - Otherwise go to GATE.
//  - GATE: wait until the resource holds the full transfer, then go to ISSUE.
//    - Write: wait for WD_CNT >= count.
//    - Read: wait for RD_FREE >= count.
//    - Reason: the controller cannot be stalled once started.
//  - ISSUE: wait for D_BUSY==0. Then drive D_REQ, D_INITADR and D_BLOCKS for exactly 1 cycle; go to WAITB.
//    - D_REQ is 0 on every other cycle, so a request is never re-triggered.
//  - WAITB: expect D_BUSY=1. If D_BUSY stays 0 for 2 cycles: set ERR, go to DONE.
//  - XFER: count beats.
//    - Write beat = D_W. Read beat = D_DOUTEN.
//    - When D_BUSY==0: if beats != count, set ERR. Go to DONE.
//  - DONE: XFER_DONE=1 for 1 cycle; go to IDLE. CMD_READY is high again in the cycle after DONE.
//  Write datapath:
//  - Each cycle D_W=1 in XFER: WD_DEQ=1 combinationally; D_DIN<=WD_DATA is registered.
//  - D_DIN is therefore valid the cycle after the D_W strobe, matching the controller's 1-cycle write-data lag.
//  - D_W with WD_CNT==0, or D_W outside a write XFER: ERR=1, WD_DEQ=0.
//  Read datapath:
//  - RD_DATA<=D_DOUT and RD_VALID<=D_DOUTEN (1-cycle latency), only in a read XFER.
//  - D_DOUTEN outside a read XFER: ERR=1 and the beat is dropped.
//  Arithmetic: beat counter CNTW bits; no wrap in-range because count <= 2^CNTW-1.
//  - Address wrap-around (MEM_LAST_ADDR) is done by the controller; this block only supplies the initial address.
//  - A CMD_ADR that is not a multiple of ADR_STEP sets ERR; the command still executes.
//  Simultaneous events: CMD_VALID during a transfer is ignored (CMD_READY=0).
//  - D_BUSY falling in the same cycle as a final beat: the beat is counted first, then completion is checked.
// CONFIGURATION
//  DRAM_XFER_PERF_EN defined:
//  - Adds outputs PERF_RD_BLK, PERF_WR_BLK and PERF_BUSY_CYC, each 32 bits.
//  - These count read beats, write beats, and cycles with D_BUSY=1.
//  - Saturating at 32'hFFFFFFFF; cleared only by reset.
//  Not defined: these ports are still present and tied to 0; no counters are synthesised.
// TESTING (bench pairs with the DRAM behavioural model, DRAM_SIZE >= 64 blocks)
//  1. Write: CMD ADR=0x40, BLOCKS=4, source holds A0..A3
//     -> one D_REQ pulse; 4 D_W beats; model mem[8..11]=A0..A3; one XFER_DONE; ERR=0.
//  2. Read back ADR=0x40, BLOCKS=4, RD_FREE=8
//     -> RD_VALID 4 cycles carrying A0..A3 in order; XFER_DONE once; D_REQ high exactly 1 cycle.
//  3. Read BLOCKS=6 with RD_FREE=3; raise RD_FREE to 6 after 20 cycles
//     -> no D_REQ before the raise; request follows; 6 beats received.
//  4. CMD_BLOCKS=0 -> D_REQ never asserted; XFER_DONE 1 cycle after accept; ERR=0.
//  5. Force D_W while IDLE; separately, write with WD_CNT falsely high and the FIFO empty
//     -> ERR=1, stays 1 until reset; drop RST_X mid-transfer -> all outputs 0, CMD_READY=1.
//  6. With DRAM_XFER_PERF_EN: run tests 1 and 2
//     -> PERF_WR_BLK=4, PERF_RD_BLK=4, PERF_BUSY_CYC = sum of busy cycles. Without the macro: all three read 0.

Source files
------------

// File: rtl/dram_xfer_initiator.sv
// DRAM block-transfer initiator: one command at a time, single-cycle request, D_DIN/RD_DATA registered (1-cycle lag).
// CMD_READY only in IDLE; the request waits until the FIFO side can absorb the whole transfer. Optional: DRAM_XFER_PERF_EN.
`ifndef DRAM_REQ_READ
`define DRAM_REQ_READ 2'b01
`endif
`ifndef DRAM_REQ_WRITE
`define DRAM_REQ_WRITE 2'b10
`endif

module dram_xfer_initiator #(
  parameter int DW       = 512,
  parameter int CNTW     = 32,
  parameter int ADR_STEP = 8
) (
  input  logic            CLK,
  input  logic            RST_X,
  input  logic            CMD_VALID,
  input  logic            CMD_WRITE,
  input  logic [31:0]     CMD_ADR,
  input  logic [CNTW-1:0] CMD_BLOCKS,
  output logic            CMD_READY,
  output logic            XFER_DONE,
  output logic            ERR,
  input  logic [DW-1:0]   WD_DATA,
  input  logic [CNTW-1:0] WD_CNT,
  output logic            WD_DEQ,
  output logic [DW-1:0]   RD_DATA,
  output logic            RD_VALID,
  input  logic [CNTW-1:0] RD_FREE,
  output logic [1:0]      D_REQ,
  output logic [31:0]     D_INITADR,
  output logic [31:0]     D_BLOCKS,
  input  logic            D_BUSY,
  input  logic            D_W,
  output logic [DW-1:0]   D_DIN,
  input  logic [DW-1:0]   D_DOUT,
  input  logic            D_DOUTEN,
  output logic [31:0]     PERF_RD_BLK,
  output logic [31:0]     PERF_WR_BLK,
  output logic [31:0]     PERF_BUSY_CYC
);

  typedef enum logic [2:0] {S_IDLE, S_GATE, S_ISSUE, S_WAITB, S_XFER, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [31:0]     adr_q, adr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] beats_q, beats_d;
  logic            idle_miss_q, idle_miss_d;
  logic            err_q, err_d;
  logic [DW-1:0]   din_q, din_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;

  logic xfer_wr, xfer_rd, wr_take, rd_take, beat, adr_misaligned, gate_ok;

  assign xfer_wr        = (state_q == S_XFER) && is_wr_q;
  assign xfer_rd        = (state_q == S_XFER) && !is_wr_q;
  assign wr_take        = D_W && xfer_wr && (WD_CNT != '0);
  assign rd_take        = D_DOUTEN && xfer_rd;
  assign beat           = is_wr_q ? D_W : D_DOUTEN;
  assign adr_misaligned = (CMD_ADR % 32'(ADR_STEP)) != 32'd0;
  // The controller cannot be stalled, so the whole transfer must fit before requesting.
  assign gate_ok        = is_wr_q ? (WD_CNT >= cnt_q) : (RD_FREE >= cnt_q);

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (CMD_VALID) state_d = (CMD_BLOCKS == '0) ? S_DONE : S_GATE;
      S_GATE:  if (gate_ok) state_d = S_ISSUE;
      S_ISSUE: if (!D_BUSY) state_d = S_WAITB;
      S_WAITB: begin
        if (D_BUSY)           state_d = S_XFER;
        else if (idle_miss_q) state_d = S_DONE;
      end
      S_XFER:  if (!D_BUSY) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    CMD_READY = (state_q == S_IDLE);
    XFER_DONE = (state_q == S_DONE);
    WD_DEQ    = wr_take;
    D_REQ     = 2'b00;
    D_INITADR = 32'd0;
    D_BLOCKS  = 32'd0;
    if (state_q == S_ISSUE && !D_BUSY) begin
      D_REQ     = is_wr_q ? `DRAM_REQ_WRITE : `DRAM_REQ_READ;
      D_INITADR = adr_q;
      D_BLOCKS  = 32'(cnt_q);
    end
  end

  always_comb begin
    is_wr_d     = is_wr_q;
    adr_d       = adr_q;
    cnt_d       = cnt_q;
    beats_d     = beats_q;
    idle_miss_d = 1'b0;
    err_d       = err_q;
    din_d       = wr_take ? WD_DATA : din_q;
    rd_valid_d  = rd_take;
    rd_data_d   = rd_take ? D_DOUT : rd_data_q;
    if (state_q == S_IDLE && CMD_VALID) begin
      is_wr_d = CMD_WRITE;
      adr_d   = CMD_ADR;
      cnt_d   = CMD_BLOCKS;
      beats_d = '0;
      if (adr_misaligned) err_d = 1'b1;
    end
    if (state_q == S_WAITB && !D_BUSY) begin
      idle_miss_d = 1'b1;
      if (idle_miss_q) err_d = 1'b1;
    end
    // A final beat coinciding with D_BUSY falling is counted before the completion check.
    if (state_q == S_XFER) begin
      beats_d = beats_q + CNTW'(beat);
      if (!D_BUSY && beats_d != cnt_q) err_d = 1'b1;
    end
    if (D_W && (!xfer_wr || WD_CNT == '0)) err_d = 1'b1;
    if (D_DOUTEN && !xfer_rd)              err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      is_wr_q     <= 1'b0;
      adr_q       <= 32'd0;
      cnt_q       <= '0;
      beats_q     <= '0;
      idle_miss_q <= 1'b0;
      err_q       <= 1'b0;
      din_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      is_wr_q     <= is_wr_d;
      adr_q       <= adr_d;
      cnt_q       <= cnt_d;
      beats_q     <= beats_d;
      idle_miss_q <= idle_miss_d;
      err_q       <= err_d;
      din_q       <= din_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign ERR      = err_q;
  assign D_DIN    = din_q;
  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;

`ifdef DRAM_XFER_PERF_EN
  logic [31:0] perf_rd_q, perf_rd_d, perf_wr_q, perf_wr_d, perf_busy_q, perf_busy_d;

  always_comb begin
    perf_rd_d   = perf_rd_q;
    perf_wr_d   = perf_wr_q;
    perf_busy_d = perf_busy_q;
    if (rd_take && perf_rd_q != 32'hFFFF_FFFF)             perf_rd_d   = perf_rd_q + 32'd1;
    if (xfer_wr && D_W && perf_wr_q != 32'hFFFF_FFFF)      perf_wr_d   = perf_wr_q + 32'd1;
    if (D_BUSY && perf_busy_q != 32'hFFFF_FFFF)            perf_busy_d = perf_busy_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      perf_rd_q   <= 32'd0;
      perf_wr_q   <= 32'd0;
      perf_busy_q <= 32'd0;
    end else begin
      perf_rd_q   <= perf_rd_d;
      perf_wr_q   <= perf_wr_d;
      perf_busy_q <= perf_busy_d;
    end
  end

  assign PERF_RD_BLK   = perf_rd_q;
  assign PERF_WR_BLK   = perf_wr_q;
  assign PERF_BUSY_CYC = perf_busy_q;
`else
  assign PERF_RD_BLK   = 32'd0;
  assign PERF_WR_BLK   = 32'd0;
  assign PERF_BUSY_CYC = 32'd0;
`endif

endmodule

// File: tb/tb_dram_xfer_initiator.sv
// Bench for dram_xfer_initiator: DRAM controller model, write-source FIFO and read scoreboard in one negedge process.
`timescale 1ns/1ps
module tb_dram_xfer_initiator;
  localparam int DW = 512;
  localparam int CNTW = 32;
  localparam int MEMN = 64;
  localparam logic [1:0] REQ_RD = 2'd1;
  localparam logic [1:0] REQ_WR = 2'd2;

  logic CLK = 1'b0;
  logic RST_X;
  logic CMD_VALID, CMD_WRITE;
  logic [31:0] CMD_ADR;
  logic [CNTW-1:0] CMD_BLOCKS;
  logic CMD_READY, XFER_DONE, ERR;
  logic [DW-1:0] WD_DATA;
  logic [CNTW-1:0] WD_CNT;
  logic WD_DEQ;
  logic [DW-1:0] RD_DATA;
  logic RD_VALID;
  logic [CNTW-1:0] RD_FREE;
  logic [1:0] D_REQ;
  logic [31:0] D_INITADR, D_BLOCKS;
  logic D_BUSY, D_W, D_DOUTEN;
  logic [DW-1:0] D_DIN, D_DOUT;
  logic [31:0] PERF_RD_BLK, PERF_WR_BLK, PERF_BUSY_CYC;

  logic [DW-1:0] mem [MEMN];
  logic [DW-1:0] wfifo[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wd_head;
  logic [CNTW-1:0] wd_cnt_true, fake_cnt;
  logic fake_en, force_dw, m_dw;
  int checks = 0, errors = 0;
  int req_cnt = 0, done_cnt = 0, deq_cnt = 0, rd_beats = 0, busy_cyc = 0;
  logic [1:0] last_op;
  logic [31:0] last_adr, last_blocks;

  assign D_W     = m_dw | force_dw;
  assign WD_DATA = wd_head;
  assign WD_CNT  = fake_en ? fake_cnt : wd_cnt_true;

  always #5 CLK = ~CLK;

  dram_xfer_initiator dut (
    .CLK(CLK), .RST_X(RST_X),
    .CMD_VALID(CMD_VALID), .CMD_WRITE(CMD_WRITE), .CMD_ADR(CMD_ADR), .CMD_BLOCKS(CMD_BLOCKS),
    .CMD_READY(CMD_READY), .XFER_DONE(XFER_DONE), .ERR(ERR),
    .WD_DATA(WD_DATA), .WD_CNT(WD_CNT), .WD_DEQ(WD_DEQ),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_FREE(RD_FREE),
    .D_REQ(D_REQ), .D_INITADR(D_INITADR), .D_BLOCKS(D_BLOCKS), .D_BUSY(D_BUSY),
    .D_W(D_W), .D_DIN(D_DIN), .D_DOUT(D_DOUT), .D_DOUTEN(D_DOUTEN),
    .PERF_RD_BLK(PERF_RD_BLK), .PERF_WR_BLK(PERF_WR_BLK), .PERF_BUSY_CYC(PERF_BUSY_CYC)
  );

  function automatic logic [DW-1:0] pat(input logic [31:0] tag);
    pat = {16{tag}};
  endfunction

  // Controller model: busy rises the cycle after the request, beats follow; write data captured one cycle after D_W.
  initial begin : env
    int m_state, m_base, m_n, m_i, w_idx;
    logic m_wr, prev_wr, pop_pend;
    logic [DW-1:0] exp_v;
    m_state = 0; m_base = 0; m_n = 0; m_i = 0; w_idx = 0;
    m_wr = 0; prev_wr = 0; pop_pend = 0;
    D_BUSY = 0; m_dw = 0; D_DOUTEN = 0; D_DOUT = '0; wd_head = '0; wd_cnt_true = '0;
    forever begin
      @(negedge CLK);
      if (!RST_X) begin
        m_state = 0; prev_wr = 0; pop_pend = 0; D_BUSY = 0; m_dw = 0; D_DOUTEN = 0;
      end else begin
        if (pop_pend && wfifo.size() > 0) void'(wfifo.pop_front());
        pop_pend = 0;
        if (prev_wr) begin
          if (w_idx < MEMN) mem[w_idx] = D_DIN;
          w_idx++;
        end
        if (RD_VALID) begin
          rd_beats++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got %h, no beat expected", RD_DATA[31:0]);
          end else begin
            exp_v = exp_q.pop_front();
            if (RD_DATA !== exp_v) begin
              errors++;
              $display("FAIL rd_data: got %h, expected %h", RD_DATA[31:0], exp_v[31:0]);
            end
          end
        end
        if (XFER_DONE) done_cnt++;
        m_dw = 0; D_DOUTEN = 0; prev_wr = 0;
        case (m_state)
          1: begin D_BUSY = 1; m_state = 2; end
          2: begin
            if (m_i < m_n) begin
              if (m_wr) begin
                m_dw = 1; prev_wr = 1;
              end else begin
                D_DOUTEN = 1;
                D_DOUT = mem[(m_base + m_i) % MEMN];
                if (m_i + 1 == m_n) begin D_BUSY = 0; m_state = 0; end
              end
              m_i++;
            end else begin
              D_BUSY = 0; m_state = 0;
            end
          end
          default: ;
        endcase
      end
      wd_cnt_true = CNTW'(wfifo.size());
      wd_head = (wfifo.size() > 0) ? wfifo[0] : '0;
      #1;
      if (RST_X) begin
        if (WD_DEQ) begin pop_pend = 1; deq_cnt++; end
        if (D_BUSY) busy_cyc++;
        if (D_REQ != 2'b00) begin
          req_cnt++;
          last_op = D_REQ; last_adr = D_INITADR; last_blocks = D_BLOCKS;
          if (m_state == 0) begin
            m_state = 1; m_wr = (D_REQ == REQ_WR);
            m_base = int'(D_INITADR >> 3); m_n = int'(D_BLOCKS); m_i = 0; w_idx = m_base;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge CLK); #2; end
  endtask

  task automatic apply_reset;
    RST_X = 0; CMD_VALID = 0; force_dw = 0; fake_en = 0;
    tick(3);
    RST_X = 1;
    tick(1);
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] adr, input logic [CNTW-1:0] blk);
    bit ok;
    ok = 0;
    CMD_VALID = 1; CMD_WRITE = wr; CMD_ADR = adr; CMD_BLOCKS = blk;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (CMD_READY) ok = 1;
      tick(1);
    end
    CMD_VALID = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL cmd_accept: CMD_READY never seen within 100 cycles"); end
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      if (XFER_DONE) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL xfer_done_timeout: no XFER_DONE within %0d cycles", budget); end
  endtask

  task automatic test_reset;
    RST_X = 0;
    tick(2);
    checks++;
    if ({CMD_READY, XFER_DONE, ERR, RD_VALID, WD_DEQ, D_REQ} !== 7'b1000000) begin
      errors++; $display("FAIL reset_ctrl: got %b, expected 1000000", {CMD_READY, XFER_DONE, ERR, RD_VALID, WD_DEQ, D_REQ});
    end
    checks++;
    if ({D_INITADR, D_BLOCKS, PERF_RD_BLK, PERF_WR_BLK, PERF_BUSY_CYC} !== '0 || D_DIN !== '0 || RD_DATA !== '0) begin
      errors++; $display("FAIL reset_data: adr %h blk %h din %h rd %h", D_INITADR, D_BLOCKS, D_DIN[31:0], RD_DATA[31:0]);
    end
    RST_X = 1;
    tick(1);
  endtask

  task automatic test_write;
    int r0, d0, q0;
    r0 = req_cnt; d0 = done_cnt; q0 = deq_cnt;
    for (int i = 0; i < 4; i++) wfifo.push_back(pat(32'hA000_0000 + i));
    send_cmd(1'b1, 32'h40, 4);
    wait_done(200);
    tick(3);
    checks++;
    if (req_cnt - r0 != 1) begin errors++; $display("FAIL wr_req_cycles: got %0d, expected 1", req_cnt - r0); end
    checks++;
    if (last_op !== REQ_WR || last_adr !== 32'h40 || last_blocks !== 32'd4) begin
      errors++; $display("FAIL wr_req_fields: got op %0d adr %h blk %0d, expected 2 40 4", last_op, last_adr, last_blocks);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8 + i] !== pat(32'hA000_0000 + i)) begin
        errors++; $display("FAIL wr_mem[%0d]: got %h, expected %h", 8 + i, mem[8 + i][31:0], 32'hA000_0000 + i);
      end
    end
    checks++;
    if (deq_cnt - q0 != 4 || wfifo.size() != 0) begin
      errors++; $display("FAIL wr_deq: got %0d pops, %0d left, expected 4 and 0", deq_cnt - q0, wfifo.size());
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL wr_done_count: got %0d, expected 1", done_cnt - d0); end
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL wr_err: got %b, expected 0", ERR); end
  endtask

  task automatic test_readback;
    int r0, d0, b0;
    r0 = req_cnt; d0 = done_cnt; b0 = rd_beats;
    for (int i = 0; i < 4; i++) exp_q.push_back(pat(32'hA000_0000 + i));
    RD_FREE = 8;
    send_cmd(1'b0, 32'h40, 4);
    wait_done(200);
    tick(3);
    checks++;
    if (req_cnt - r0 != 1 || last_op !== REQ_RD) begin
      errors++; $display("FAIL rd_req: got %0d cycles op %0d, expected 1 cycle op 1", req_cnt - r0, last_op);
    end
    checks++;
    if (rd_beats - b0 != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL rd_beats: got %0d beats, %0d pending, expected 4 and 0", rd_beats - b0, exp_q.size());
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL rd_done_count: got %0d, expected 1", done_cnt - d0); end
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL rd_err: got %b, expected 0", ERR); end
  endtask

  task automatic test_perf;
    logic [31:0] e_wr, e_rd, e_busy;
`ifdef DRAM_XFER_PERF_EN
    e_wr = 32'd4; e_rd = 32'd4; e_busy = 32'(busy_cyc);
`else
    e_wr = 32'd0; e_rd = 32'd0; e_busy = 32'd0;
`endif
    checks++;
    if (PERF_WR_BLK !== e_wr) begin errors++; $display("FAIL perf_wr: got %0d, expected %0d", PERF_WR_BLK, e_wr); end
    checks++;
    if (PERF_RD_BLK !== e_rd) begin errors++; $display("FAIL perf_rd: got %0d, expected %0d", PERF_RD_BLK, e_rd); end
    checks++;
    if (PERF_BUSY_CYC !== e_busy) begin errors++; $display("FAIL perf_busy: got %0d, expected %0d", PERF_BUSY_CYC, e_busy); end
  endtask

  task automatic test_read_gate;
    int r0, b0;
    b0 = rd_beats;
    for (int i = 0; i < 6; i++) exp_q.push_back(pat(32'h5A00_0000 + 16 + i));
    RD_FREE = 3;
    send_cmd(1'b0, 32'h80, 6);
    r0 = req_cnt;
    tick(20);
    checks++;
    if (req_cnt != r0 || CMD_READY !== 1'b0) begin
      errors++; $display("FAIL gate_hold: got %0d requests ready %b, expected 0 and 0", req_cnt - r0, CMD_READY);
    end
    RD_FREE = 6;
    wait_done(200);
    tick(3);
    checks++;
    if (req_cnt - r0 != 1) begin errors++; $display("FAIL gate_req: got %0d, expected 1", req_cnt - r0); end
    checks++;
    if (rd_beats - b0 != 6 || exp_q.size() != 0) begin
      errors++; $display("FAIL gate_beats: got %0d beats, %0d pending, expected 6 and 0", rd_beats - b0, exp_q.size());
    end
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL gate_err: got %b, expected 0", ERR); end
  endtask

  task automatic test_zero_blocks;
    int r0;
    r0 = req_cnt;
    send_cmd(1'b0, 32'h40, 0);
    checks++;
    if (XFER_DONE !== 1'b1) begin errors++; $display("FAIL zero_done: got %b, expected 1", XFER_DONE); end
    tick(1);
    checks++;
    if (XFER_DONE !== 1'b0 || CMD_READY !== 1'b1) begin
      errors++; $display("FAIL zero_after: got done %b ready %b, expected 0 1", XFER_DONE, CMD_READY);
    end
    checks++;
    if (req_cnt != r0 || ERR !== 1'b0) begin
      errors++; $display("FAIL zero_req_err: got %0d requests err %b, expected 0 and 0", req_cnt - r0, ERR);
    end
    send_cmd(1'b0, 32'h44, 0);
    tick(2);
    checks++;
    if (ERR !== 1'b1) begin errors++; $display("FAIL misaligned_err: got %b, expected 1", ERR); end
  endtask

  task automatic test_errors;
    int r0, q0, d0;
    bit seen;
    apply_reset();
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b, expected 0", ERR); end
    force_dw = 1;
    #1;
    checks++;
    if (WD_DEQ !== 1'b0) begin errors++; $display("FAIL idle_dw_deq: got %b, expected 0", WD_DEQ); end
    tick(1);
    force_dw = 0;
    tick(1);
    checks++;
    if (ERR !== 1'b1) begin errors++; $display("FAIL idle_dw_err: got %b, expected 1", ERR); end
    tick(5);
    checks++;
    if (ERR !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b, expected 1", ERR); end
    apply_reset();
    r0 = req_cnt; q0 = deq_cnt; d0 = done_cnt;
    fake_en = 1; fake_cnt = 4;
    send_cmd(1'b1, 32'h100, 4);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (req_cnt != r0) seen = 1;
      else tick(1);
    end
    fake_en = 0;
    checks++;
    if (!seen) begin errors++; $display("FAIL empty_req_timeout: no request within 50 cycles"); end
    wait_done(200);
    tick(3);
    checks++;
    if (deq_cnt != q0 || ERR !== 1'b1 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL empty_fifo: got %0d pops err %b done %0d, expected 0 1 1", deq_cnt - q0, ERR, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    int b0;
    bit seen;
    apply_reset();
    b0 = rd_beats;
    RD_FREE = 8;
    for (int i = 0; i < 6; i++) exp_q.push_back(pat(32'h5A00_0000 + 16 + i));
    send_cmd(1'b0, 32'h80, 6);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (rd_beats - b0 >= 2) seen = 1;
      else tick(1);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_beats_timeout: fewer than 2 beats within 100 cycles"); end
    RST_X = 0;
    #1;
    checks++;
    if ({CMD_READY, XFER_DONE, ERR, RD_VALID, WD_DEQ, D_REQ} !== 7'b1000000) begin
      errors++; $display("FAIL mid_reset_ctrl: got %b, expected 1000000", {CMD_READY, XFER_DONE, ERR, RD_VALID, WD_DEQ, D_REQ});
    end
    checks++;
    if ({D_INITADR, D_BLOCKS} !== 64'd0 || D_DIN !== '0 || RD_DATA !== '0) begin
      errors++; $display("FAIL mid_reset_data: adr %h blk %h din %h rd %h", D_INITADR, D_BLOCKS, D_DIN[31:0], RD_DATA[31:0]);
    end
    exp_q.delete();
    tick(2);
    RST_X = 1;
    tick(2);
  endtask

  initial begin
    RST_X = 0; CMD_VALID = 0; CMD_WRITE = 0; CMD_ADR = '0; CMD_BLOCKS = '0;
    RD_FREE = '0; fake_en = 0; fake_cnt = '0; force_dw = 0;
    last_op = '0; last_adr = '0; last_blocks = '0;
    for (int i = 0; i < MEMN; i++) mem[i] = pat(32'h5A00_0000 + i);
    test_reset();
    test_write();
    test_readback();
    test_perf();
    test_read_gate();
    test_zero_blocks();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
